// File: rtl/uart_rx_buffer_pkg.sv
// rtl/uart_rx_buffer_pkg.sv - shared constants for the UART receive buffer
// Holds the receiver FSM state encodings and the default timing/depth values.

package uart_rx_buffer_pkg;

   // 100 MHz clock, 115200 baud
   localparam int CLKS_PER_BIT_DEF = 868;
   localparam int DEPTH_LOG2_DEF   = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_buffer_rx_byte_fifo.sv
// rtl/uart_rx_buffer_rx_byte_fifo.sv - show-ahead byte FIFO for received UART data
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   push        : write push_data this edge (dropped when full unless popping too)
//   push_data   : byte to store
//   pop         : remove the head byte this edge (ignored when empty)
//   head        : current head byte, valid while empty==0
//   empty, full : occupancy flags

module rx_byte_fifo
   import uart_rx_buffer_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head,
   output logic       empty,
   output logic       full
);

   localparam int                    DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = DEPTH[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;

   logic [7:0]            mem_q [DEPTH];
   logic [7:0]            mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH_CNT);
   assign head  = mem_q[rd_ptr_q];

   // A pop frees the slot the push needs, so full+push+pop is allowed.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; head is only meaningful while not empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - 8N1 UART receiver feeding a show-ahead byte FIFO
// Ports:
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   rs_rx         : asynchronous serial input, idles high, LSB first
//   pop           : remove head byte (CPU-side rx_fifo_pop)
//   received_data : FIFO head byte, valid while waiting==0
//   waiting       : FIFO empty
//   overflow      : sticky, a received byte was dropped on a full FIFO
//   framing_error : one-cycle pulse when a stop bit samples low

module uart_rx_buffer
   import uart_rx_buffer_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DEPTH_LOG2   = DEPTH_LOG2_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rs_rx,
   input  logic       pop,
   output logic [7:0] received_data,
   output logic       waiting,
   output logic       overflow,
   output logic       framing_error
);

   localparam int               CNT_W       = $clog2(CLKS_PER_BIT + 1);
   // Counter reaches zero N cycles after loading N-1, which is the sample edge.
   localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = 1;

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             err_wait_q, err_wait_d;
   logic             fe_q, fe_d;
   logic             overflow_q, overflow_d;
   logic             line, tick, push;
   logic             fifo_empty, fifo_full;

   assign line = sync2_q;
   assign tick = (cnt_q == '0);

   always_comb begin
      sync1_d    = rs_rx;
      sync2_d    = sync1_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      err_wait_d = err_wait_q;
      fe_d       = 1'b0;
      push       = 1'b0;

      if (!tick) begin
         cnt_d = cnt_q - CNT_ONE;
      end

      case (state_q)
         ST_IDLE: begin
            if (!line) begin
               state_d = ST_START;
               cnt_d   = HALF_RELOAD;
            end
         end
         ST_START: begin
            if (tick) begin
               if (line) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DATA;
                  cnt_d   = FULL_RELOAD;
                  idx_d   = 3'd0;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_d[idx_q] = line;
               cnt_d          = FULL_RELOAD;
               if (idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         ST_STOP: begin
            // After a bad stop bit, hold here until the line returns high so
            // the low tail of the broken frame is not taken as a start bit.
            if (err_wait_q) begin
               if (line) begin
                  state_d    = ST_IDLE;
                  err_wait_d = 1'b0;
               end
            end else if (tick) begin
               if (line) begin
                  push    = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  fe_d       = 1'b1;
                  err_wait_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign overflow_d = overflow_q | (push & fifo_full & ~pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= 3'd0;
         shift_q    <= 8'd0;
         err_wait_q <= 1'b0;
         fe_q       <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         err_wait_q <= err_wait_d;
         fe_q       <= fe_d;
         overflow_q <= overflow_d;
      end
   end

   rx_byte_fifo #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (shift_q),
      .pop       (pop),
      .head      (received_data),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign waiting       = fifo_empty;
   assign overflow      = overflow_q;
   assign framing_error = fe_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - self-checking bench for uart_rx_buffer

module tb_uart_rx_buffer;

   localparam int CPB   = 16;
   localparam int DL    = 2;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       rs_rx;
   logic       pop;
   logic [7:0] received_data;
   logic       waiting;
   logic       overflow;
   logic       framing_error;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         fe_cnt = 0;
   logic [7:0] exp_q[$];
   logic       exp_ovf;

   uart_rx_buffer #(
      .CLKS_PER_BIT(CPB),
      .DEPTH_LOG2  (DL)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rs_rx         (rs_rx),
      .pop           (pop),
      .received_data (received_data),
      .waiting       (waiting),
      .overflow      (overflow),
      .framing_error (framing_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (framing_error === 1'b1) fe_cnt++;
   end

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic do_reset();
      reset = 1'b1;
      rs_rx = 1'b1;
      pop   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      exp_ovf = 1'b0;
   endtask

   task automatic model_push(input logic [7:0] b, input logic pop_same);
      logic [7:0] dummy;
      if (pop_same && exp_q.size() != 0) dummy = exp_q.pop_front();
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovf = 1'b1;
   endtask

   task automatic drive_bit(input logic b);
      rs_rx = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_data_bits(input logic [7:0] b);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
   endtask

   // Stop sample lands 11 edges into the stop bit: 2 sync flops, one IDLE
   // edge, then half a bit to mid-start.
   task automatic send_frame(input logic [7:0] b, input int stop_low, input logic pop_at_stop);
      send_data_bits(b);
      if (stop_low > 0) begin
         repeat (stop_low) drive_bit(1'b0);
         drive_bit(1'b1);
      end else begin
         rs_rx = 1'b1;
         repeat (10) @(posedge clk);
         #1;
         if (pop_at_stop) pop = 1'b1;
         @(posedge clk);
         #1;
         pop = 1'b0;
         model_push(b, pop_at_stop);
         repeat (5) @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input string tag);
      logic [7:0] e;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (waiting !== 1'b0) begin
            n_bad++;
            $display("FAIL %s waiting: got %b expected 0", tag, waiting);
         end
         n_cmp++;
         if (received_data !== e) begin
            n_bad++;
            $display("FAIL %s data: got %02h expected %02h", tag, received_data, e);
         end
         pop = 1'b1;
         @(posedge clk);
         #1;
         pop = 1'b0;
      end
      n_cmp++;
      if (waiting !== 1'b1) begin
         n_bad++;
         $display("FAIL %s empty_after_drain: got %b expected 1", tag, waiting);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (waiting !== 1'b1) begin
         n_bad++; $display("FAIL reset_waiting: got %b expected 1", waiting);
      end
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow);
      end
      n_cmp++;
      if (framing_error !== 1'b0) begin
         n_bad++; $display("FAIL reset_framing: got %b expected 0", framing_error);
      end
   endtask

   task automatic test_single();
      do_reset();
      send_data_bits(8'hA5);
      rs_rx = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      n_cmp++;
      if (waiting !== 1'b1) begin
         n_bad++; $display("FAIL single_before_stop: got %b expected 1", waiting);
      end
      @(posedge clk);
      #1;
      model_push(8'hA5, 1'b0);
      n_cmp++;
      if (waiting !== 1'b0) begin
         n_bad++; $display("FAIL single_after_stop: got %b expected 0", waiting);
      end
      repeat (5) @(posedge clk);
      #1;
      drain("single");
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_frame(8'h01, 0, 1'b0);
      send_frame(8'h02, 0, 1'b0);
      send_frame(8'h03, 0, 1'b0);
      n_cmp++;
      if (overflow !== exp_ovf) begin
         n_bad++; $display("FAIL b2b_overflow: got %b expected %b", overflow, exp_ovf);
      end
      drain("b2b");
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 0, 1'b0);
      n_cmp++;
      if (overflow !== exp_ovf) begin
         n_bad++; $display("FAIL ovf_set: got %b expected %b", overflow, exp_ovf);
      end
      drain("ovf");
      n_cmp++;
      if (overflow !== 1'b1) begin
         n_bad++; $display("FAIL ovf_sticky: got %b expected 1", overflow);
      end
      do_reset();
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_bad++; $display("FAIL ovf_cleared: got %b expected 0", overflow);
      end
   endtask

   task automatic test_glitch();
      int fe0;
      do_reset();
      fe0 = fe_cnt;
      rs_rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rs_rx = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      n_cmp++;
      if (waiting !== 1'b1) begin
         n_bad++; $display("FAIL glitch_waiting: got %b expected 1", waiting);
      end
      n_cmp++;
      if (fe_cnt - fe0 != 0) begin
         n_bad++; $display("FAIL glitch_framing: got %0d pulses expected 0", fe_cnt - fe0);
      end
      drain("glitch");
   endtask

   task automatic test_framing();
      int fe0;
      do_reset();
      fe0 = fe_cnt;
      send_frame(8'h55, 2, 1'b0);
      n_cmp++;
      if (fe_cnt - fe0 != 1) begin
         n_bad++; $display("FAIL framing_pulses: got %0d expected 1", fe_cnt - fe0);
      end
      n_cmp++;
      if (waiting !== 1'b1) begin
         n_bad++; $display("FAIL framing_nopush: got %b expected 1", waiting);
      end
      send_frame(8'h66, 0, 1'b0);
      drain("framing_next");
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      do_reset();
      b = 8'h77;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(b[i]);
      rs_rx = b[3];
      repeat (8) @(posedge clk);
      #1;
      do_reset();
      repeat (20) @(posedge clk);
      #1;
      send_frame(8'h88, 0, 1'b0);
      drain("reset_mid");
   endtask

   task automatic test_full_pop_at_stop();
      do_reset();
      for (int i = 0; i < 4; i++) send_frame(8'h20 + 8'(i), 0, 1'b0);
      send_frame(8'h24, 0, 1'b1);
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_bad++; $display("FAIL full_pop_overflow: got %b expected 0", overflow);
      end
      n_cmp++;
      if (exp_q.size() != DEPTH) begin
         n_bad++; $display("FAIL full_pop_model_count: got %0d expected %0d", exp_q.size(), DEPTH);
      end
      drain("full_pop");
   endtask

   initial begin
      reset = 1'b1;
      rs_rx = 1'b1;
      pop   = 1'b0;
      exp_ovf = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_glitch();
      test_framing();
      test_reset_mid();
      test_full_pop_at_stop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, is the number of clk cycles per serial bit (100 MHz, 115200 baud).
REQ-002 Parameter DEPTH_LOG2, default 4, sets the FIFO depth to 2**DEPTH_LOG2 bytes.
REQ-003 Port clk  input  1  is the single clock; every register is clocked on its rising edge.
REQ-004 Port reset  input  1  is the synchronous, active-high reset.
REQ-005 Port rs_rx  input  1  is the asynchronous serial line; it idles high, sends 8N1 frames, LSB first.
REQ-006 Port pop  input  1  removes the head byte on the next edge; connects to the CPU-side rx_fifo_pop.
REQ-007 Port received_data  output  8  is the FIFO head byte (show-ahead).
REQ-008 Port waiting  output  1  is high when the FIFO is empty; connects to rx_waiting.
REQ-009 Port overflow  output  1  is a sticky flag: a byte was dropped because the FIFO was full.
REQ-010 Port framing_error  output  1  is a one-cycle pulse when a stop bit samples low.

Function
REQ-011 rs_rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; "line" below means the synchronizer output.
REQ-012 The receiver FSM SHALL have exactly four states: IDLE, START, DATA, STOP; it also has a bit-period counter and a 3-bit bit index.
REQ-013 IDLE: on line==0, go to START and load the counter so the next sample is taken CLKS_PER_BIT/2 cycles later.
REQ-014 START: at the mid-bit sample, line==1 returns to IDLE (glitch, nothing pushed); line==0 goes to DATA with the counter reloaded to CLKS_PER_BIT.
REQ-015 DATA: sample once every CLKS_PER_BIT cycles and shift the sample into bit [index]; after index 7, go to STOP.
REQ-016 STOP: sample one CLKS_PER_BIT later.
  - line==1: push the byte into the FIFO and go to IDLE.
  - line==0: discard the byte, pulse framing_error, and wait in STOP until line==1, then go to IDLE.
REQ-017 A pushed byte SHALL appear on received_data, with waiting low, on the cycle after the stop-bit sample edge.
REQ-018 received_data SHALL equal mem[rd_ptr] combinationally whenever waiting==0; its value is don't-care while waiting==1.
REQ-019 pop while waiting==1 SHALL be ignored; pointers and count do not change.
REQ-020 A push while the FIFO is full and pop==0 SHALL drop the byte and set overflow; FIFO contents are unchanged.
REQ-021 Push and pop in the same cycle while full SHALL both take effect; count is unchanged and overflow is not set.
REQ-022 Push and pop in the same cycle while empty: the push takes effect and the pop is ignored.
REQ-023 rd_ptr and wr_ptr SHALL be DEPTH_LOG2 bits wide and wrap modulo depth; count SHALL be DEPTH_LOG2+1 bits wide.
REQ-024 A back-to-back frame (next start bit immediately after the stop bit) SHALL be received without loss.

Reset
REQ-025 On reset: FSM goes to IDLE, synchronizer flops go to 1, pointers and count go to 0, waiting=1, overflow=0, framing_error=0, received_data=0 is not required.
REQ-026 Reset asserted mid-frame SHALL abandon the partial byte; reception resumes at the next falling edge after reset deasserts.

Structure
REQ-027 A shared package/include SHALL hold the FSM state encodings and the default CLKS_PER_BIT and DEPTH_LOG2 values.
REQ-028 The FIFO SHALL be a separate sub-module, rx_byte_fifo (push, push_data, pop, head, empty, full), instantiated once.

Verification (bench runs with CLKS_PER_BIT=16, DEPTH_LOG2=2)
REQ-029 Send frame 0xA5 -> waiting falls 1 cycle after the stop sample, received_data=0xA5; pop -> waiting=1 on the next cycle.
REQ-030 Send 0x01, 0x02, 0x03 back-to-back with no pops -> reads 0x01, 0x02, 0x03 in order; overflow stays 0.
REQ-031 Send 5 frames 0x10..0x14 with no pops -> FIFO holds 0x10..0x13, 0x14 is dropped, overflow=1 until reset.
REQ-032 Pulse rs_rx low for 4 cycles only -> FSM returns to IDLE, nothing pushed, waiting stays 1.
REQ-033 Send 0x55 with the stop bit held low for 2 bit times -> framing_error pulses once, nothing pushed; a following frame 0x66 is received correctly.
REQ-034 Assert reset during DATA bit 3 of 0x77, then send 0x88 -> only 0x88 is received; with the FIFO full, pop on the same edge as the stop sample -> count stays at 4, overflow=0.
